// File: rtl/fir_pkg.sv
// Shared definitions for the streaming FIR MAC engine: FSM state encoding
// and default geometry constants.
package fir_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_NUM_TAP    = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Multiply-accumulate unit: wrapping two's-complement product folded into a
// running sum; clr restarts the sum with the current product.
module fir_mac_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] acc_o
);

  logic signed [DATA_WIDTH-1:0] acc_q;

  function automatic logic signed [DATA_WIDTH-1:0] wrap_mul(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] full;
    full = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    return $signed(full[DATA_WIDTH-1:0]);
  endfunction

  // Accumulate stage: operands are the BRAM registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= (clr_i ? '0 : acc_q) + wrap_mul($signed(a_i), $signed(b_i));
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_engine.sv
// Streaming FIR engine: circular sample history in the data BRAM, taps in the
// tap BRAM, one NUM_TAP-step MAC per input sample, one result per sample.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_TAP    = DEF_NUM_TAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ap_start,
  input  logic [31:0]           data_length,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic                  ss_tvalid,
  input  logic [DATA_WIDTH-1:0] ss_tdata,
  output logic                  ss_tready,
  output logic                  sm_tvalid,
  output logic [DATA_WIDTH-1:0] sm_tdata,
  output logic                  sm_tlast,
  input  logic                  sm_tready,
  output logic                  tap_re,
  output logic [ADDR_WIDTH-1:0] tap_raddr,
  input  logic [DATA_WIDTH-1:0] tap_rdo,
  output logic                  data_we,
  output logic [ADDR_WIDTH-1:0] data_waddr,
  output logic [DATA_WIDTH-1:0] data_wdi,
  output logic                  data_re,
  output logic [ADDR_WIDTH-1:0] data_raddr,
  input  logic [DATA_WIDTH-1:0] data_rdo
);

  localparam logic [ADDR_WIDTH-1:0] TAP_CNT   = ADDR_WIDTH'(NUM_TAP);
  localparam logic [ADDR_WIDTH-1:0] LAST_STEP = ADDR_WIDTH'(NUM_TAP - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   step_q;
  logic [ADDR_WIDTH-1:0]   head_q;
  logic [31:0]             cnt_q;
  logic [31:0]             len_q;
  logic                    vld_p1;
  logic                    clr_p1;
  logic                    mac_phase;
  logic                    in_hs;
  logic                    is_last;
  logic [ADDR_WIDTH-1:0]   rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      head_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            len_q   <= data_length;
            cnt_q   <= '0;
            head_q  <= '0;
            step_q  <= '0;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (step_q == LAST_STEP) begin
            step_q  <= '0;
            state_q <= (len_q == 32'd0) ? S_DONE : S_WAIT_IN;
          end else begin
            step_q <= step_q + ONE;
          end
        end
        S_WAIT_IN: begin
          if (ss_tvalid) begin
            step_q  <= '0;
            state_q <= S_MAC;
          end
        end
        // One extra step after the last read lets the final product land.
        S_MAC: begin
          if (step_q == TAP_CNT) begin
            step_q  <= '0;
            state_q <= S_OUT;
          end else begin
            step_q <= step_q + ONE;
          end
        end
        S_OUT: begin
          if (sm_tready) begin
            head_q  <= (head_q == LAST_STEP) ? '0 : head_q + ONE;
            cnt_q   <= cnt_q + 32'd1;
            state_q <= is_last ? S_DONE : S_WAIT_IN;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mac_phase = (state_q == S_MAC) && (step_q < TAP_CNT);
  assign in_hs     = (state_q == S_WAIT_IN) && ss_tvalid;
  assign is_last   = (cnt_q == len_q - 32'd1);
  assign rd_idx    = (head_q >= step_q) ? (head_q - step_q)
                                        : (head_q + TAP_CNT - step_q);

  assign ap_idle    = (state_q == S_IDLE);
  assign ap_done    = (state_q == S_DONE);
  assign ss_tready  = (state_q == S_WAIT_IN);
  assign sm_tvalid  = (state_q == S_OUT);
  assign sm_tlast   = (state_q == S_OUT) && is_last;

  assign tap_re     = mac_phase;
  assign tap_raddr  = mac_phase ? step_q : '0;
  assign data_re    = mac_phase;
  assign data_raddr = mac_phase ? rd_idx : '0;

  assign data_we    = (state_q == S_CLEAR) || in_hs;
  assign data_waddr = (state_q == S_CLEAR) ? step_q : (in_hs ? head_q : '0);
  assign data_wdi   = in_hs ? ss_tdata : '0;

  // Read-issue to read-data boundary: BRAM outputs valid one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      clr_p1 <= 1'b0;
    end else begin
      vld_p1 <= mac_phase;
      clr_p1 <= mac_phase && (step_q == '0);
    end
  end

  fir_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_p1),
    .en_i  (vld_p1),
    .a_i   (tap_rdo),
    .b_i   (data_rdo),
    .acc_o (sm_tdata)
  );

endmodule

// File: tb/tb_fir_mac_engine.sv
// Scoreboard bench for fir_mac_engine: BRAM models, a convolution reference
// model feeding an expected-result queue, and a monitor that pops on output.
module tb_fir_mac_engine;

  localparam int NT = 11;

  typedef struct {
    logic [31:0] d;
    bit          last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ap_start;
  logic [31:0] data_length;
  logic        ap_idle, ap_done;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tready;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready = 1'b0;
  logic        tap_re;
  logic [11:0] tap_raddr;
  logic [31:0] tap_rdo = '0;
  logic        data_we;
  logic [11:0] data_waddr;
  logic [31:0] data_wdi;
  logic        data_re;
  logic [11:0] data_raddr;
  logic [31:0] data_rdo = '0;

  logic [31:0] h [NT];
  logic [31:0] data_mem [16];
  logic [31:0] xs [$];
  exp_t        q [$];
  exp_t        e_mon;

  int  checks = 0;
  int  errors = 0;
  int  out_idx = 0;
  int  bp_at = -1;
  int  bp_cnt = 0;
  bit  rand_rdy = 0;
  bit  done_due = 0;
  bit  idle_due = 0;
  bit  allow_done = 0;
  bit  hold_v = 0;
  logic [31:0] hold_d;

  always #5 clk = ~clk;

  fir_mac_engine dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .sm_tready(sm_tready),
    .tap_re(tap_re), .tap_raddr(tap_raddr), .tap_rdo(tap_rdo),
    .data_we(data_we), .data_waddr(data_waddr), .data_wdi(data_wdi),
    .data_re(data_re), .data_raddr(data_raddr), .data_rdo(data_rdo)
  );

  // BRAM models: registered read, write at the edge.
  always @(posedge clk) begin
    if (tap_re) tap_rdo <= (tap_raddr < 12'(NT)) ? h[tap_raddr] : 32'hDEAD_BEEF;
    if (data_re) data_rdo <= data_mem[data_raddr[3:0]];
    if (data_we) data_mem[data_waddr[3:0]] <= data_wdi;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Output ready driver, with an optional forced 5-cycle stall on one output.
  always @(posedge clk) begin
    #1;
    if (out_idx == bp_at && bp_cnt < 5) begin
      sm_tready = 1'b0;
      if (sm_tvalid) bp_cnt++;
    end else begin
      sm_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: compares every output handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      hold_v   = 0;
      done_due = 0;
      idle_due = 0;
    end else begin
      if (done_due) begin
        chk("ap_done_pulse", 32'(ap_done), 32'd1);
        done_due = 0;
        idle_due = 1;
      end else begin
        if (idle_due) begin
          chk("ap_idle_after_done", 32'(ap_idle), 32'd1);
          idle_due = 0;
        end
        if (ap_done && !allow_done) chk("ap_done_spurious", 32'(ap_done), 32'd0);
      end
      if (sm_tvalid) begin
        chk("ss_tready_while_out", 32'(ss_tready), 32'd0);
        if (hold_v) chk("sm_tdata_stable", sm_tdata, hold_d);
        if (sm_tready) begin
          hold_v = 0;
          if (q.size() == 0) begin
            chk("unexpected_output", 32'(sm_tvalid), 32'd0);
          end else begin
            e_mon = q.pop_front();
            chk($sformatf("y[%0d]", out_idx), sm_tdata, e_mon.d);
            chk($sformatf("tlast[%0d]", out_idx), 32'(sm_tlast), 32'(e_mon.last));
            if (e_mon.last) done_due = 1;
          end
          out_idx++;
        end else begin
          hold_v = 1;
          hold_d = sm_tdata;
        end
      end else begin
        hold_v = 0;
      end
    end
  end

  // Reference: y[n] = sum_k h[k]*x[n-k], zero history, arithmetic mod 2^32.
  task automatic model(input int len);
    logic [31:0] acc;
    exp_t e;
    for (int n = 0; n < len; n++) begin
      acc = '0;
      for (int k = 0; k < NT; k++)
        if (n - k >= 0) acc = acc + h[k] * xs[n-k];
      e.d = acc;
      e.last = (n == len - 1);
      q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int len);
    data_length = len;
    @(posedge clk); #1 ap_start = 1'b1;
    @(posedge clk); #1 ap_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] x);
    int cyc = 0;
    ss_tvalid = 1'b1;
    ss_tdata  = x;
    forever begin
      @(negedge clk);
      if (ss_tready) break;
      cyc++;
      if (cyc > 300) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    ss_tvalid = 1'b0;
    ss_tdata  = '0;
  endtask

  task automatic run(input int len, input bit gaps, input bit lat);
    int cyc = 0;
    out_idx = 0;
    model(len);
    pulse_start(len);
    for (int n = 0; n < len; n++) begin
      if (gaps) repeat ($urandom_range(0, 4)) @(posedge clk);
      send(xs[n]);
      if (lat && n == 0) begin
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("latency_pre", 32'(sm_tvalid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("latency_T13", 32'(sm_tvalid), 32'd1);
      end
    end
    while ((q.size() != 0 || !ap_idle) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_complete", 32'(cyc < 3000), 32'd1);
    @(posedge clk);
  endtask

  task automatic set_taps_rand();
    for (int k = 0; k < NT; k++)
      h[k] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; ap_start = 1'b0; ss_tvalid = 1'b0; ss_tdata = '0; data_length = '0;
    for (int k = 0; k < NT; k++) h[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ap_idle", 32'(ap_idle), 32'd1);
    chk("rst_ap_done", 32'(ap_done), 32'd0);
    chk("rst_ss_tready", 32'(ss_tready), 32'd0);
    chk("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    chk("rst_sm_tdata", sm_tdata, 32'd0);
    chk("rst_sm_tlast", 32'(sm_tlast), 32'd0);
    chk("rst_re_we", {29'd0, tap_re, data_re, data_we}, 32'd0);
    chk("rst_addrs", {8'd0, tap_raddr, data_raddr}, 32'd0);
    chk("rst_wdi", data_wdi | 32'(data_waddr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Impulse response, with first-output latency check.
    h[0] = 32'd1;
    xs = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    run(5, 0, 1);

    // All-ones taps over 15 samples exercises head wrap-around.
    for (int k = 0; k < NT; k++) h[k] = 32'd1;
    xs.delete();
    for (int n = 1; n <= 15; n++) xs.push_back(32'(n));
    run(15, 1, 0);

    // Output backpressure held 5 cycles on the third result.
    xs.delete();
    for (int n = 0; n < 6; n++) xs.push_back(32'($urandom_range(0, 1000)));
    bp_cnt = 0; bp_at = 2;
    run(6, 0, 0);
    chk("bp_stall_cycles", 32'(bp_cnt), 32'd5);
    bp_at = -1;

    // Randomized taps, samples, input gaps and output ready.
    set_taps_rand();
    xs.delete();
    for (int n = 0; n < 20; n++) xs.push_back($urandom);
    rand_rdy = 1;
    run(20, 1, 0);
    rand_rdy = 0;

    // Back-to-back run: stale history must have been cleared.
    set_taps_rand();
    h[0] = 32'd2;
    xs = {32'd7, $urandom, $urandom};
    run(3, 0, 0);

    // Wrap-around overflow and negative product.
    for (int k = 0; k < NT; k++) h[k] = '0;
    h[0] = 32'h0001_0000;
    xs = {32'h0001_0000, 32'd3};
    run(2, 0, 0);
    h[0] = 32'hFFFF_FFFF;
    xs = {32'd5};
    run(1, 0, 0);

    // Reset asserted mid-MAC.
    set_taps_rand();
    pulse_start(3);
    send($urandom);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ap_idle", 32'(ap_idle), 32'd1);
    chk("midrst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    chk("midrst_ss_tready", 32'(ss_tready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Zero-length run: done right after CLEAR, no output.
    allow_done = 1;
    out_idx = 0;
    pulse_start(0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ap_done && cyc < 50);
    chk("zl_done_latency", 32'(cyc), 32'(NT + 1));
    @(negedge clk);
    chk("zl_idle_after", 32'(ap_idle), 32'd1);
    chk("zl_no_output", 32'(out_idx), 32'd0);
    allow_done = 0;

    // Post-zero-length run still works.
    for (int k = 0; k < NT; k++) h[k] = 32'(k + 1);
    xs = {32'd3, 32'hFFFF_FFFE, 32'd9};
    run(3, 1, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
